// File: rtl/life_rule_stage.sv
// Life-rule compute stage: masked 3x3 neighbourhood -> next cell state, written to the opposite frame.
// Optional LIFE_RULE_PROG_EN adds birth_mask/survive_mask inputs for a programmable rule.
module life_rule_stage #(
    parameter int ADDR_WIDTH = 2,
    parameter int POP_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [8:0]            read_enable_in,
    input  logic [8:0]            write_enable_in,
    input  logic [ADDR_WIDTH-1:0] write_addr_in,
    input  logic                  frame_buffer_select_in,
    input  logic [8:0]            read_data,
`ifdef LIFE_RULE_PROG_EN
    input  logic [8:0]            birth_mask,
    input  logic [8:0]            survive_mask,
`endif
    output logic [8:0]            write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_data,
    output logic                  write_frame_select,
    output logic                  generation_done,
    output logic [POP_WIDTH-1:0]  population,
    output logic                  onehot_err
);

    localparam logic [POP_WIDTH-1:0] POP_MAX = '1;

    typedef struct packed {
        logic [8:0]            we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [8:0]            re;
        logic                  fsel;
    } s1_req_t;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    s1_req_t               s1;
    logic                  s1_valid;
    logic [POP_WIDTH-1:0]  acc;
    logic                  trk_valid;
    logic                  trk_sel;

    logic [8:0]            masked;
    logic                  centre;
    logic                  centre_in_mask;
    logic [3:0]            neighbours;
    logic                  next_state;
    logic                  boundary;

    // Banks map one-to-one onto neighbourhood positions, so no rotation is needed.
    always_comb begin
        masked         = read_data & s1.re;
        centre         = |(read_data & s1.we);
        centre_in_mask = |(s1.re & s1.we);
        neighbours     = popcount9(masked) - {3'b000, centre & centre_in_mask};
`ifdef LIFE_RULE_PROG_EN
        next_state     = (neighbours <= 4'd8) ?
                         (birth_mask[neighbours] | (centre & survive_mask[neighbours])) : 1'b0;
`else
        next_state     = (neighbours == 4'd3) | (centre & (neighbours == 4'd2));
`endif
        boundary       = s1_valid & trk_valid & ((~s1.fsel) != trk_sel);
    end

    // Stage 0 -> S1 capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= enable;
            if (enable) begin
                s1 <= '{we: write_enable_in, addr: write_addr_in,
                        re: read_enable_in, fsel: frame_buffer_select_in};
            end
        end
    end

    // Stage 2 write outputs; data fields hold across bubbles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            write_enable       <= '0;
            write_addr         <= '0;
            write_data         <= 1'b0;
            write_frame_select <= 1'b0;
        end else begin
            write_enable <= s1_valid ? s1.we : 9'h000;
            if (s1_valid) begin
                write_addr         <= s1.addr;
                write_data         <= next_state;
                write_frame_select <= ~s1.fsel;
            end
        end
    end

    // Population tracking, aligned with the write it accounts for
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc             <= '0;
            population      <= '0;
            generation_done <= 1'b0;
            trk_valid       <= 1'b0;
            trk_sel         <= 1'b0;
        end else begin
            generation_done <= 1'b0;
            if (s1_valid) begin
                trk_valid <= 1'b1;
                trk_sel   <= ~s1.fsel;
                if (boundary) begin
                    generation_done <= 1'b1;
                    population      <= acc;
                    acc             <= {{(POP_WIDTH-1){1'b0}}, next_state};
                end else if (next_state && acc != POP_MAX) begin
                    acc <= acc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            onehot_err <= 1'b0;
        else if (enable && popcount9(write_enable_in) != 4'd1)
            onehot_err <= 1'b1;
    end

endmodule

// File: tb/tb_life_rule_stage.sv
// Scoreboard bench for life_rule_stage: expected writes queued at stimulus time, compared per test.
module tb_life_rule_stage;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [8:0] read_enable_in = '0;
    logic [8:0] write_enable_in = '0;
    logic [1:0] write_addr_in = '0;
    logic       frame_buffer_select_in = 1'b0;
    logic [8:0] read_data = '0;
    logic [8:0] write_enable;
    logic [1:0] write_addr;
    logic       write_data;
    logic       write_frame_select;
    logic       generation_done;
    logic [5:0] population;
    logic       onehot_err;
`ifdef LIFE_RULE_PROG_EN
    logic [8:0] birth_mask = 9'h008;
    logic [8:0] survive_mask = 9'h00C;
`endif

    always #5 clk = ~clk;

    life_rule_stage #(.ADDR_WIDTH(2), .POP_WIDTH(6)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .read_enable_in(read_enable_in), .write_enable_in(write_enable_in),
        .write_addr_in(write_addr_in), .frame_buffer_select_in(frame_buffer_select_in),
        .read_data(read_data),
`ifdef LIFE_RULE_PROG_EN
        .birth_mask(birth_mask), .survive_mask(survive_mask),
`endif
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .write_frame_select(write_frame_select), .generation_done(generation_done),
        .population(population), .onehot_err(onehot_err)
    );

    typedef struct packed {
        logic [8:0] we;
        logic [1:0] addr;
        logic       wd;
        logic       wfs;
        logic       gd;
        logic [5:0] pop;
        logic       err;
        logic       full;
    } out_t;

    out_t exp_q[$];
    out_t obs_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference pipeline state: pending S1 cell plus generation bookkeeping
    logic       p_valid = 1'b0;
    logic [8:0] p_we;
    logic [1:0] p_addr;
    logic       p_fsel;
    logic       p_wd;
    logic [5:0] m_acc = '0;
    logic [5:0] m_pop = '0;
    logic       m_trk_v = 1'b0;
    logic       m_trk = 1'b0;
    logic       m_err = 1'b0;
    logic       m_clean = 1'b1;

    // One clock: drive a request plus read data for the previous request; exp_wd is the
    // rule result the caller expects for the cell requested in this cycle.
    task automatic step(input logic en, input logic [8:0] we, input logic [1:0] addr,
                        input logic [8:0] re, input logic fsel, input logic [8:0] rd,
                        input logic exp_wd);
        out_t e, o;
        enable = en; write_enable_in = we; write_addr_in = addr;
        read_enable_in = re; frame_buffer_select_in = fsel; read_data = rd;
        e = '0;
        if (!resetn) begin
            e.full = 1'b1; p_valid = 1'b0; m_acc = '0; m_pop = '0;
            m_trk_v = 1'b0; m_err = 1'b0; m_clean = 1'b1;
        end else begin
            if (p_valid) begin
                e.we = p_we; e.addr = p_addr; e.wd = p_wd; e.wfs = ~p_fsel;
                e.full = 1'b1; m_clean = 1'b0;
                if (m_trk_v && e.wfs != m_trk) begin
                    e.gd = 1'b1; m_pop = m_acc; m_acc = {5'b0, p_wd};
                end else if (p_wd && m_acc != 6'h3F) begin
                    m_acc = m_acc + 6'd1;
                end
                m_trk_v = 1'b1; m_trk = e.wfs;
            end else begin
                e.full = m_clean;
            end
            e.pop = m_pop;
            if (en && $countones(we) != 1) m_err = 1'b1;
            e.err = m_err;
            p_valid = en; p_we = we; p_addr = addr; p_fsel = fsel; p_wd = exp_wd;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        o = {write_enable, write_addr, write_data, write_frame_select,
             generation_done, population, onehot_err, 1'b0};
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        out_t e, o;
        resetn = 1'b0;
        step(1'b1, 9'h010, 2'd3, 9'h1FF, 1'b1, 9'h1FF, 1'b1);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        resetn = 1'b1;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (o !== e) $display("FAIL reset_state: got %p need %p", o, e);
            else passed++;
        end
    endtask

    // Centre live with two live neighbours survives
    task automatic test_survive_single();
        out_t e, o;
        int k = 0;
        step(1'b1, 9'h010, 2'd2, 9'h1FF, 1'b0, 9'h000, 1'b1);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h0B0, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL survive_out[%0d]: got %p need %p", k, o, e);
            else passed++;
            if (k == 1) begin
                checks++;
                if ({o.we, o.wd} !== {9'h010, 1'b1})
                    $display("FAIL survive_write: got we=%h wd=%b need we=010 wd=1", o.we, o.wd);
                else passed++;
            end
            k++;
        end
    endtask

    // Birth on three neighbours, then the same data with edge banks masked off
    task automatic test_birth_mask();
        out_t e, o;
        step(1'b1, 9'h010, 2'd0, 9'h1FF, 1'b0, 9'h000, 1'b1);
        step(1'b1, 9'h010, 2'd1, 9'h1F8, 1'b0, 9'h007, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h007, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL birth_mask: got %p need %p", o, e);
            else passed++;
        end
    endtask

    task automatic test_enable_gaps();
        out_t e, o;
        int k = 0;
        step(1'b1, 9'h001, 2'd3, 9'h1FF, 1'b0, 9'h000, 1'b1);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h00E, 1'b0);
        step(1'b1, 9'h100, 2'd2, 9'h1FF, 1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h100, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL gap_out[%0d]: got %p need %p", k, o, e);
            else passed++;
            if (k >= 1 && k <= 3) begin
                checks++;
                if (o.we !== ((k == 1) ? 9'h001 : (k == 3) ? 9'h100 : 9'h000))
                    $display("FAIL gap_we[%0d]: got %h", k, o.we);
                else passed++;
            end
            k++;
        end
    endtask

    function automatic bit cell_at(input bit [35:0] g, input int r, input int c);
        if (r < 0 || r > 5 || c < 0 || c > 5) return 1'b0;
        return g[r*6 + c];
    endfunction

    function automatic bit life_next(input bit [35:0] g, input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) n += int'(cell_at(g, r + dr, c + dc));
        return (n == 3) || (g[r*6 + c] && n == 2);
    endfunction

    // 6x6 blinker scanned for three generations back to back
    task automatic test_blinker();
        out_t e, o;
        bit [35:0]  g, gn;
        logic [8:0] we, re, rd, prev_rd;
        logic [1:0] addr;
        int         pulses = 0;
        resetn = 1'b0;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        resetn = 1'b1;
        g = '0;
        g[2*6+1] = 1'b1; g[2*6+2] = 1'b1; g[2*6+3] = 1'b1;
        prev_rd = '0;
        for (int gen = 0; gen < 3; gen++) begin
            gn = '0;
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) begin
                    gn[r*6 + c] = life_next(g, r, c);
                    we = 9'h000; re = 9'h000; rd = 9'h000;
                    we[3*(r%3) + (c%3)] = 1'b1;
                    addr = 2'(2*(r/3) + (c/3));
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            int rr, cc, b;
                            rr = r + dr; cc = c + dc;
                            b = 3*(((rr % 3) + 3) % 3) + (((cc % 3) + 3) % 3);
                            if (rr >= 0 && rr < 6 && cc >= 0 && cc < 6) begin
                                re[b] = 1'b1; rd[b] = cell_at(g, rr, cc);
                            end else begin
                                rd[b] = 1'b1;
                            end
                        end
                    step(1'b1, we, addr, re, gen[0], prev_rd, gn[r*6 + c]);
                    prev_rd = rd;
                end
            g = gn;
        end
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, prev_rd, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL blinker_out: got %p need %p", o, e);
            else passed++;
            if (o.gd === 1'b1) begin
                pulses++;
                checks++;
                if (o.pop !== 6'd3) $display("FAIL blinker_pop: got %0d need 3", o.pop);
                else passed++;
            end
        end
        checks++;
        if (pulses != 2) $display("FAIL blinker_pulses: got %0d need 2", pulses);
        else passed++;
    endtask

    // More live writes than the counter holds, then a boundary
    task automatic test_saturation();
        out_t e, o;
        resetn = 1'b0;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        resetn = 1'b1;
        step(1'b1, 9'h010, 2'd0, 9'h1FF, 1'b0, 9'h000, 1'b1);
        for (int i = 0; i < 70; i++)
            step(1'b1, 9'h010, 2'(i), 9'h1FF, 1'b0, 9'h038, 1'b1);
        step(1'b1, 9'h010, 2'd0, 9'h1FF, 1'b1, 9'h038, 1'b1);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h038, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL saturate_out: got %p need %p", o, e);
            else passed++;
        end
        checks++;
        if (population !== 6'h3F) $display("FAIL saturate_pop: got %0d need 63", population);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        out_t e, o;
        step(1'b1, 9'h010, 2'd1, 9'h1FF, 1'b0, 9'h000, 1'b0);
        step(1'b1, 9'h020, 2'd1, 9'h1FF, 1'b0, 9'h000, 1'b0);
        resetn = 1'b0;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        resetn = 1'b1;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL midflight_reset: got %p need %p", o, e);
            else passed++;
        end
    endtask

    task automatic test_onehot_err();
        out_t e, o;
        step(1'b1, 9'h003, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        checks++;
        if (onehot_err !== 1'b1) $display("FAIL onehot_sticky: got %b need 1", onehot_err);
        else passed++;
        resetn = 1'b0;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        resetn = 1'b1;
        step(1'b0, 9'h000, 2'd0, 9'h000, 1'b0, 9'h000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); o.full = e.full; checks++;
            if (e.full ? (o !== e) : ({o.we, o.gd, o.pop, o.err} !== {e.we, e.gd, e.pop, e.err}))
                $display("FAIL onehot_out: got %p need %p", o, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_survive_single();
        test_birth_mask();
        test_enable_gaps();
        test_blinker();
        test_saturation();
        test_reset_midflight();
        test_onehot_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
